hist_accum_multi: RTL and testbench

Multi-channel histogram accumulator, the parametrised successor to the single-channel histogram RAM block. It takes a pixel stream carrying one bin index per channel and counts every channel in the same cycle, using an independent read-modify-write pipeline per channel with same-bin forwarding. It sits between the pixel front end and the histogram consumers (equaliser, statistics readout), which read the finished histogram through a registered read port. An internal sweep clears all bins after reset and on `clear`.

---
 rtl/hist_accum_multi_if.sv | 32 +++
 rtl/hist_accum_multi.sv | 152 +++++++++++++++
 tb/tb_hist_accum_multi.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hist_accum_multi_if.sv
// hist_accum_multi_if: pixel stream, readout port and status signals of the
// multi-channel histogram accumulator. clk/arstn stay plain module ports.
interface hist_accum_multi_if #(
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned BIN_WIDTH   = 8,
  parameter int unsigned COUNT_WIDTH = 19
);
  localparam int unsigned CH_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*BIN_WIDTH-1:0] pix_in;
  logic                          pix_valid;
  logic                          frame_end;
  logic                          clear;
  logic [CH_WIDTH-1:0]           rd_chan;
  logic [BIN_WIDTH-1:0]          rd_addr;
  logic                          rd_valid;
  logic [COUNT_WIDTH-1:0]        rd_data;
  logic                          rd_data_valid;
  logic                          busy;
  logic                          done;
  logic                          sat_flag;

  modport master (
    output pix_in, pix_valid, frame_end, clear, rd_chan, rd_addr, rd_valid,
    input  rd_data, rd_data_valid, busy, done, sat_flag
  );

  modport slave (
    input  pix_in, pix_valid, frame_end, clear, rd_chan, rd_addr, rd_valid,
    output rd_data, rd_data_valid, busy, done, sat_flag
  );
endinterface

// File: rtl/hist_accum_multi.sv
// hist_accum_multi: per-channel histogram with a 3-stage read-modify-write
// pipeline (issue read / data / write back) and same-bin forwarding.
// An internal sweep zeroes every bin after reset and on clear.
// Optional macro HIST_SATURATE_EN: counts clamp at all-ones and set sat_flag;
// without it counts wrap and sat_flag stays 0.
module hist_accum_multi #(
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned BIN_WIDTH   = 8,
  parameter int unsigned COUNT_WIDTH = 19
) (
  input logic               clk,
  input logic               arstn,
  hist_accum_multi_if.slave bus
);
  localparam int unsigned BINS     = 2 ** BIN_WIDTH;
  localparam int unsigned CH_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {CLEAR, ACCUM, DRAIN, DONE} state_t;

  state_t                 state;
  logic [BIN_WIDTH-1:0]   clr_addr;
  logic                   drain_cnt;
  logic                   accept;
  logic                   s1_valid;
  logic                   s2_valid;
  logic                   rd_pend;
  logic [COUNT_WIDTH-1:0] rd_q;
  logic [COUNT_WIDTH-1:0] rd_word;

  logic [COUNT_WIDTH-1:0] mem     [CHANNELS][BINS];
  logic [BIN_WIDTH-1:0]   s1_bin  [CHANNELS];
  logic [BIN_WIDTH-1:0]   s2_bin  [CHANNELS];
  logic [COUNT_WIDTH-1:0] s1_data [CHANNELS];
  logic [COUNT_WIDTH-1:0] s2_data [CHANNELS];
  logic [COUNT_WIDTH-1:0] s1_base [CHANNELS];
  logic [COUNT_WIDTH-1:0] s1_next [CHANNELS];

`ifdef HIST_SATURATE_EN
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  logic s1_sat [CHANNELS];
  logic sat_any;
`endif

  // Pixels are taken only in ACCUM; a simultaneous clear aborts them.
  assign accept = (state == ACCUM) && bus.pix_valid && !bus.clear;

  // S1: pick the newest count for the bin (S2 write in flight wins) and increment.
  always_comb begin
`ifdef HIST_SATURATE_EN
    sat_any = 1'b0;
`endif
    for (int c = 0; c < CHANNELS; c++) begin
      s1_base[c] = (s2_valid && (s2_bin[c] == s1_bin[c])) ? s2_data[c] : s1_data[c];
`ifdef HIST_SATURATE_EN
      s1_sat[c]  = (s1_base[c] == CNT_MAX);
      s1_next[c] = s1_sat[c] ? CNT_MAX : s1_base[c] + COUNT_WIDTH'(1);
      sat_any    = sat_any | s1_sat[c];
`else
      s1_next[c] = s1_base[c] + COUNT_WIDTH'(1);
`endif
    end
  end

  // Readout channel mux; out-of-range channels read as 0.
  always_comb begin
    rd_word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.rd_chan == CH_WIDTH'(c)) rd_word = mem[c][bus.rd_addr];
    end
  end

  // Datapath: bin RAMs, pipeline payload and readout capture.
  always_ff @(posedge clk) begin
    rd_q <= rd_word;
    for (int c = 0; c < CHANNELS; c++) begin
      s1_bin[c]  <= bus.pix_in[c*BIN_WIDTH +: BIN_WIDTH];
      // S0 read; a write landing on the same bin this edge is forwarded.
      s1_data[c] <= (s2_valid && (s2_bin[c] == bus.pix_in[c*BIN_WIDTH +: BIN_WIDTH]))
                    ? s2_data[c] : mem[c][bus.pix_in[c*BIN_WIDTH +: BIN_WIDTH]];
      s2_bin[c]  <= s1_bin[c];
      s2_data[c] <= s1_next[c];
      if (arstn) begin
        if (state == CLEAR) begin
          mem[c][clr_addr] <= '0;
        end else if (s2_valid && !bus.clear) begin
          mem[c][s2_bin[c]] <= s2_data[c];
        end
      end
    end
  end

  // Control FSM, pipeline valids and registered status/readout outputs.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      state             <= CLEAR;
      clr_addr          <= '0;
      drain_cnt         <= 1'b0;
      s1_valid          <= 1'b0;
      s2_valid          <= 1'b0;
      rd_pend           <= 1'b0;
      bus.rd_data       <= '0;
      bus.rd_data_valid <= 1'b0;
      bus.busy          <= 1'b1;
      bus.done          <= 1'b0;
      bus.sat_flag      <= 1'b0;
    end else begin
      s1_valid          <= accept;
      s2_valid          <= s1_valid && !bus.clear;
      rd_pend           <= (state == DONE) && bus.rd_valid;
      bus.rd_data_valid <= rd_pend;
      if (rd_pend) bus.rd_data <= rd_q;
`ifdef HIST_SATURATE_EN
      if (s1_valid && sat_any) bus.sat_flag <= 1'b1;
`else
      bus.sat_flag <= 1'b0;
`endif
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + BIN_WIDTH'(1);
          if (&clr_addr) begin
            state    <= ACCUM;
            bus.busy <= 1'b0;
          end
        end
        ACCUM: begin
          if (bus.frame_end) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
            bus.busy  <= 1'b1;
          end
        end
        DRAIN: begin
          // Two cycles cover the S1 and S2 stages of the last pixel.
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        default: ;
      endcase
      if (bus.clear) begin
        state        <= CLEAR;
        clr_addr     <= '0;
        bus.busy     <= 1'b1;
        bus.done     <= 1'b0;
        bus.sat_flag <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_hist_accum_multi.sv
// tb_hist_accum_multi: two instances (19-bit and 3-bit counters) share one
// stimulus stream; an unbounded per-bin count model gives expected values.
module tb_hist_accum_multi;
  localparam int unsigned CH  = 3;
  localparam int unsigned BW  = 8;
  localparam int unsigned NB  = 256;
  localparam int unsigned CW1 = 19;
  localparam int unsigned CW2 = 3;

  logic clk = 1'b0;
  logic arstn;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;
  int   cnt [CH][NB];

  always #5 clk = ~clk;

  hist_accum_multi_if #(.CHANNELS(CH), .BIN_WIDTH(BW), .COUNT_WIDTH(CW1)) bus1 ();
  hist_accum_multi_if #(.CHANNELS(CH), .BIN_WIDTH(BW), .COUNT_WIDTH(CW2)) bus2 ();

  assign bus2.pix_in    = bus1.pix_in;
  assign bus2.pix_valid = bus1.pix_valid;
  assign bus2.frame_end = bus1.frame_end;
  assign bus2.clear     = bus1.clear;
  assign bus2.rd_chan   = bus1.rd_chan;
  assign bus2.rd_addr   = bus1.rd_addr;
  assign bus2.rd_valid  = bus1.rd_valid;

  hist_accum_multi #(.CHANNELS(CH), .BIN_WIDTH(BW), .COUNT_WIDTH(CW1)) dut1 (
    .clk(clk), .arstn(arstn), .bus(bus1));
  hist_accum_multi #(.CHANNELS(CH), .BIN_WIDTH(BW), .COUNT_WIDTH(CW2)) dut2 (
    .clk(clk), .arstn(arstn), .bus(bus2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus1.pix_valid = 1'b0;
    bus1.frame_end = 1'b0;
    bus1.clear     = 1'b0;
    bus1.rd_valid  = 1'b0;
  endtask

  task automatic model_zero();
    foreach (cnt[c, b]) cnt[c][b] = 0;
  endtask

  // Expected readout of an unbounded count in a w-bit counter.
  function automatic logic [31:0] exp_cnt(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
`ifdef HIST_SATURATE_EN
    return 32'((v > mx) ? mx : v);
`else
    return 32'(v & mx);
`endif
  endfunction

  function automatic logic over(input int w);
    foreach (cnt[c, b]) if (cnt[c][b] > (1 << w) - 1) return 1'b1;
    return 1'b0;
  endfunction

  // One stream cycle; random reads are issued alongside and must be ignored.
  task automatic send(input logic [BW-1:0] b0, b1, b2, input logic v, input logic fe);
    bus1.pix_in    = {b2, b1, b0};
    bus1.pix_valid = v;
    bus1.frame_end = fe;
    bus1.rd_valid  = 1'($urandom % 2);
    bus1.rd_chan   = 2'($urandom % CH);
    bus1.rd_addr   = 8'($urandom);
    step();
    if (v) begin
      cnt[0][b0]++;
      cnt[1][b1]++;
      cnt[2][b2]++;
    end
    chk("accum_no_rd_dv", 32'(bus1.rd_data_valid), 32'(0));
  endtask

  // Called right after the frame_end edge: checks drain timing, then pokes pixels in DONE.
  task automatic finish_frame();
    idle();
    chk("drain_busy", 32'(bus1.busy), 32'(1));
    chk("drain_done_t1", 32'(bus1.done), 32'(0));
    step();
    chk("drain_done_t2", 32'(bus1.done), 32'(0));
    step();
    chk("done_t3_dut1", 32'(bus1.done), 32'(1));
    chk("done_t3_dut2", 32'(bus2.done), 32'(1));
    chk("done_busy", 32'(bus1.busy), 32'(0));
    for (int i = 0; i < 4; i++) begin
      bus1.pix_valid = 1'b1;
      bus1.pix_in    = 24'($urandom);
      step();
    end
    idle();
  endtask

  // Streams one read per cycle over every bin of every channel.
  task automatic readback();
    int total;
    int j;
    total = CH * NB;
    for (int i = 0; i <= total + 1; i++) begin
      if (i < total) begin
        bus1.rd_valid = 1'b1;
        bus1.rd_chan  = 2'(i / NB);
        bus1.rd_addr  = 8'(i % NB);
      end else begin
        bus1.rd_valid = 1'b0;
      end
      step();
      if (i >= 1 && i <= total) begin
        j = i - 1;
        chk("rd_dv1", 32'(bus1.rd_data_valid), 32'(1));
        chk("rd_dv2", 32'(bus2.rd_data_valid), 32'(1));
        chk($sformatf("rd1 c%0d b%0d", j / NB, j % NB), 32'(bus1.rd_data),
            exp_cnt(cnt[j / NB][j % NB], CW1));
        chk($sformatf("rd2 c%0d b%0d", j / NB, j % NB), 32'(bus2.rd_data),
            exp_cnt(cnt[j / NB][j % NB], CW2));
      end else if (i == total + 1) begin
        chk("rd_dv1_end", 32'(bus1.rd_data_valid), 32'(0));
        chk("rd_dv2_end", 32'(bus2.rd_data_valid), 32'(0));
      end
    end
  endtask

  // Waits out the sweep while driving pixels that must be ignored.
  task automatic sweep_wait();
    int n;
    n = 0;
    while (bus1.busy && n < 1000) begin
      bus1.pix_valid = 1'($urandom % 2);
      bus1.pix_in    = 24'($urandom);
      n++;
      step();
    end
    idle();
    chk("sweep_len", 32'(n), 32'(256));
    chk("sweep_busy2", 32'(bus2.busy), 32'(0));
  endtask

  task automatic do_clear();
    bus1.clear     = 1'b1;
    bus1.pix_valid = 1'b1;
    bus1.pix_in    = 24'($urandom);
    step();
    idle();
    model_zero();
    chk("clear_done", 32'(bus1.done), 32'(0));
    chk("clear_sat2", 32'(bus2.sat_flag), 32'(0));
    chk("clear_busy", 32'(bus1.busy), 32'(1));
    sweep_wait();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, 32'(bus1.busy), 32'(1));
    chk({tag, "_done"}, 32'(bus1.done), 32'(0));
    chk({tag, "_sat1"}, 32'(bus1.sat_flag), 32'(0));
    chk({tag, "_sat2"}, 32'(bus2.sat_flag), 32'(0));
    chk({tag, "_rd_data"}, 32'(bus1.rd_data), 32'(0));
    chk({tag, "_rd_dv"}, 32'(bus1.rd_data_valid), 32'(0));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic fe;
    logic v;
    logic [BW-1:0] pat [5];
    pat[0] = 8'd3; pat[1] = 8'd4; pat[2] = 8'd3; pat[3] = 8'd3; pat[4] = 8'd4;

    // Reset and the initial sweep.
    arstn        = 1'b0;
    idle();
    bus1.pix_in  = '0;
    bus1.rd_chan = '0;
    bus1.rd_addr = '0;
    model_zero();
    step(); step(); step();
    reset_checks("reset");
    arstn = 1'b1;
    sweep_wait();

    // Empty frame: everything reads 0.
    send(8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    finish_frame();
    readback();

    // Back-to-back pixels on one bin per channel.
    do_clear();
    for (int i = 0; i < 5; i++) send(8'd7, 8'd7, 8'd200, 1'b1, 1'b0);
    send(8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    finish_frame();
    chk("fwd_sat1", 32'(bus1.sat_flag), 32'(0));
    readback();

    // Interleaved hazard on ch0, frame_end on the last pixel; single-read latency.
    do_clear();
    for (int i = 0; i < 5; i++) send(pat[i], 8'($urandom), 8'($urandom), 1'b1, 1'(i == 4));
    finish_frame();
    bus1.rd_valid = 1'b1;
    bus1.rd_chan  = 2'd0;
    bus1.rd_addr  = 8'd3;
    step();
    idle();
    chk("lat_t1_dv", 32'(bus1.rd_data_valid), 32'(0));
    step();
    chk("lat_t2_dv", 32'(bus1.rd_data_valid), 32'(1));
    chk("lat_t2_bin3", 32'(bus1.rd_data), 32'(3));
    step();
    chk("lat_t3_dv", 32'(bus1.rd_data_valid), 32'(0));
    readback();

    // Saturation / wrap on the 3-bit instance.
    do_clear();
    for (int i = 0; i < 10; i++) send(8'd1, 8'd1, 8'd1, 1'b1, 1'(i == 9));
    finish_frame();
`ifdef HIST_SATURATE_EN
    chk("sat2_set", 32'(bus2.sat_flag), 32'(1));
`else
    chk("sat2_tied", 32'(bus2.sat_flag), 32'(0));
`endif
    chk("sat1_none", 32'(bus1.sat_flag), 32'(0));
    readback();

    // Clear in the middle of a frame.
    do_clear();
    for (int i = 0; i < 100; i++) send(8'd9, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
    do_clear();
    for (int i = 0; i < 4; i++) send(8'd9, 8'($urandom), 8'($urandom), 1'b1, 1'(i == 3));
    finish_frame();
    readback();

    // Random frame with gaps and a narrow bin range to provoke hazards.
    do_clear();
    for (int i = 0; i < 400; i++) begin
      fe = 1'(i == 399);
      v  = fe | 1'($urandom % 4 != 0);
      if ($urandom % 2 == 0)
        send(8'($urandom % 4), 8'($urandom % 4), 8'($urandom % 4), v, fe);
      else
        send(8'($urandom), 8'($urandom), 8'($urandom), v, fe);
    end
    finish_frame();
`ifdef HIST_SATURATE_EN
    chk("rand_sat2", 32'(bus2.sat_flag), 32'(over(CW2)));
`else
    chk("rand_sat2", 32'(bus2.sat_flag), 32'(0));
`endif
    readback();

    // Reset in the middle of a frame.
    do_clear();
    for (int i = 0; i < 20; i++) send(8'($urandom % 3), 8'($urandom), 8'($urandom % 3), 1'b1, 1'b0);
    idle();
    arstn = 1'b0;
    step(); step();
    reset_checks("midreset");
    arstn = 1'b1;
    model_zero();
    sweep_wait();
    for (int i = 0; i < 50; i++) send(8'($urandom % 8), 8'($urandom), 8'($urandom % 2), 1'b1, 1'(i == 49));
    finish_frame();
    readback();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
